debounce_scheduler: RTL and testbench
=====================================

# debounce_scheduler

Multi-channel switch debounce controller that shares one hold timer among `N_CH` raw switch inputs. Each input is synchronised and compared with its committed stable level. A round-robin scheduler grants the single timer to one pending channel at a time and commits the new level only if the input holds for `HOLD_CYCLES` clocks. It sits between the board-level switch pins and the user-logic that consumes clean levels and edge pulses.

## Interface
- `N_CH`, default 8: number of switch channels, 2..32.
- `HOLD_CYCLES`, default 10: clocks a level must stay unchanged in TIMING before commit, ≥2.
- `IDX_W`, default `$clog2(N_CH)`: channel index width.
- `CNT_W`, default `$clog2(HOLD_CYCLES)`: timer width.
- `clk`  in  1  sole clock; all logic rises on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `q`  in  N_CH  raw, asynchronous switch levels.
- `enable`  in  1  scheduler enable; low blocks new grants and aborts the current one.
- `Q`  out  N_CH  committed debounced levels.
- `rise`  out  N_CH  one-cycle pulse when `Q[i]` commits 0→1.
- `fall`  out  N_CH  one-cycle pulse when `Q[i]` commits 1→0.
- `busy`  out  1  high in TIMING or COMMIT.
- `active_ch`  out  IDX_W  channel owning the timer; valid while `busy`.
- `abort`  out  1  one-cycle pulse when a timed channel reverts before commit.

## Operation
- Per channel: two-flop synchroniser `sync[i]`; pending when `sync[i] != Q[i]`.
- FSM states:
  - IDLE: if `enable` and any pending, pick the first pending index at or after `rr_ptr`, wrapping. Load `active_ch`, clear timer, go to TIMING.
  - TIMING: if `sync[active_ch] == Q[active_ch]` (revert) or `enable` low, pulse `abort`, set `rr_ptr = active_ch+1` (mod N_CH), go to IDLE. Otherwise increment the timer. When the timer equals `HOLD_CYCLES-1` on an edge that is not an abort, go to COMMIT.
  - COMMIT: `Q[active_ch] <= sync[active_ch]`, pulse `rise` or `fall` for that channel, set `rr_ptr = active_ch+1` (mod N_CH), go to IDLE.
- Revert has priority over reaching terminal count in the same cycle: abort, no commit.
- Non-active channels may become pending or stop pending at any time. A channel that returns to its `Q` level before being granted is never timed.
- IDLE always lasts at least one cycle between grants.
- Worst-case commit latency for one channel: `(N_CH-1)*(HOLD_CYCLES+2) + HOLD_CYCLES + 4` clocks.
- `rise`/`fall` are never both high for one channel. At most one channel pulses per cycle.

## Timing
- Reset (async, `reset`=0): `Q`, `rise`, `fall`, `sync`, `busy`, `abort`, `active_ch`, `rr_ptr` and timer all 0; state IDLE. Takes effect immediately, including mid-TIMING. No pulse is emitted on reset exit.
- Channels that are high at reset release go through normal debounce; there is no bypass.
- Uncontended latency: new raw level sampled at edge 1, `sync` at edge 2, grant at edge 3, TIMING occupies edges 3..HOLD_CYCLES+2, COMMIT entered at edge HOLD_CYCLES+3. `Q`/`rise`/`fall` update at edge HOLD_CYCLES+4; the pulse is high for the following cycle only.
- `abort` is asserted in the cycle after the edge that detected the revert. The state is IDLE in that same cycle.
- `enable` deassert: no grant on the next edge. An active TIMING aborts on the next edge. A COMMIT already entered still completes.
- Timer never exceeds `HOLD_CYCLES-1`. No wrap inside TIMING.

## Structure
- Package `debounce_pkg`: FSM state typedef (IDLE=2'd0, TIMING=2'd1, COMMIT=2'd2) and default parameter constants.
- Sub-module `debounce_timer`: `clear`, `tick`, `done` (timer == HOLD_CYCLES-1), parameterised by `HOLD_CYCLES`.
- Round-robin pick implemented as a function in the top level.
- Synchronisers stay in the top level.

## Test plan
- Clean press, `HOLD_CYCLES`=10: `q[0]` 0→1 before edge 1, held → `Q[0]`=1 and `rise[0]` high for one cycle after edge 14; `busy` high for 11 cycles.
- Bounce: `q[2]` rises and is granted, then reverts 5 cycles into TIMING → `abort` pulses once, `Q[2]` stays 0, no `rise[2]`. A later stable rise commits normally.
- Simultaneous events, `rr_ptr`=0: `q[1]` and `q[5]` rise on the same edge → ch1 commits at edge 14 and ch5 at edge 26; `active_ch` goes 1 then 5.
- Round-robin fairness: after ch5 commits with ch1 and ch6 pending → ch6 is granted before ch1.
- Reset mid-TIMING: assert `reset`=0 during ch3 TIMING → all outputs are 0 immediately. After release with `q[3]` still high, ch3 re-debounces from scratch: `rise[3]` after edge 14 of the new sampling.
- `enable`=0 during TIMING → `abort` next cycle and no grants while low. Re-enable → the pending channel is granted on the next edge.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: FSM state type and default parameters shared by the debounce scheduler
package debounce_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TIMING = 2'd1, COMMIT = 2'd2} state_t;
  localparam int DEF_N_CH = 8;
  localparam int DEF_HOLD_CYCLES = 10;
endpackage

// File: rtl/debounce_timer.sv
// debounce_timer: shared hold timer, saturates at HOLD_CYCLES-1 and flags done there
module debounce_timer
  import debounce_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_W = $clog2(HOLD_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic done
);
  logic [CNT_W-1:0] cnt;
  assign done = cnt == CNT_W'(HOLD_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= clear ? '0 : (tick && !done) ? cnt + CNT_W'(1) : cnt;
endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: multi-channel switch debouncer sharing one round-robin hold timer
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int IDX_W = $clog2(N_CH),
  parameter int CNT_W = $clog2(HOLD_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  q,
  input  logic             enable,
  output logic [N_CH-1:0]  Q,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall,
  output logic             busy,
  output logic [IDX_W-1:0] active_ch,
  output logic             abort
);
  state_t state, state_n;
  logic [N_CH-1:0] sync_a, sync, pending, oh;
  logic [IDX_W-1:0] rr_ptr, ptr_n, ach_n, nxt;
  logic clear, tick, done, abort_n, commit;
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CH-1:0] p, input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] r;
    r = ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      if (p[j]) r = IDX_W'(j);
    end
    return r;
  endfunction
  assign pending = sync ^ Q;
  assign oh = {{(N_CH - 1){1'b0}}, 1'b1} << active_ch;
  assign nxt = (active_ch == IDX_W'(N_CH - 1)) ? '0 : active_ch + IDX_W'(1);
  assign busy = state != IDLE;
  debounce_timer #(.HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .clear(clear), .tick(tick), .done(done)
  );
  always_comb begin
    state_n = state;
    ach_n = active_ch;
    ptr_n = rr_ptr;
    clear = 1'b0;
    tick = 1'b0;
    abort_n = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE:
        if (enable && |pending) begin
          ach_n = rr_pick(pending, rr_ptr);
          clear = 1'b1;
          state_n = TIMING;
        end
      TIMING:
        if (!pending[active_ch] || !enable) begin
          abort_n = 1'b1;
          ptr_n = nxt;
          state_n = IDLE;
        end else if (done) state_n = COMMIT;
        else tick = 1'b1;
      COMMIT: begin
        commit = 1'b1;
        ptr_n = nxt;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sync_a <= '0;
      sync <= '0;
      Q <= '0;
      rise <= '0;
      fall <= '0;
      abort <= 1'b0;
      active_ch <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      sync_a <= q;
      sync <= sync_a;
      active_ch <= ach_n;
      rr_ptr <= ptr_n;
      abort <= abort_n;
      Q <= commit ? (Q & ~oh) | (sync & oh) : Q;
      rise <= commit ? oh & sync & ~Q : '0;
      fall <= commit ? oh & ~sync & Q : '0;
    end
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: table-driven and hand-sequenced checks of the debounce scheduler
module tb_debounce_scheduler;
  logic clk, reset, enable, busy, abort;
  logic [7:0] q, Q, rise, fall;
  logic [2:0] active_ch;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [7:0] q;
    logic en;
    int adv;
    logic [7:0] eq, er, ef;
    logic eb, ea;
    logic [2:0] ech;
  } vec_t;
  vec_t tbl[$];
  debounce_scheduler dut (
    .clk(clk), .reset(reset), .q(q), .enable(enable), .Q(Q), .rise(rise),
    .fall(fall), .busy(busy), .active_ch(active_ch), .abort(abort)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, step, act, exp);
    end
  endtask
  task automatic chk_all(input int step, input logic [7:0] eq, input logic [7:0] er, input logic [7:0] ef,
                         input logic eb, input logic ea, input logic [2:0] ech);
    chk("Q", step, 32'(Q), 32'(eq));
    chk("rise", step, 32'(rise), 32'(er));
    chk("fall", step, 32'(fall), 32'(ef));
    chk("busy", step, 32'(busy), 32'(eb));
    chk("abort", step, 32'(abort), 32'(ea));
    if (eb) chk("active_ch", step, 32'(active_ch), 32'(ech));
  endtask
  initial begin
    tbl.push_back('{8'h01, 1'b1, 2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h01, 1'b1, 1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{8'h01, 1'b1, 9, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{8'h01, 1'b1, 1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{8'h01, 1'b1, 1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h01, 1'b1, 1, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h00, 1'b1, 13, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0});
    tbl.push_back('{8'h00, 1'b1, 1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h22, 1'b1, 3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd1});
    tbl.push_back('{8'h22, 1'b1, 11, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h22, 1'b1, 1, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 3'd5});
    tbl.push_back('{8'h60, 1'b1, 11, 8'h22, 8'h20, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h60, 1'b1, 1, 8'h22, 8'h00, 8'h00, 1'b1, 1'b0, 3'd6});
    tbl.push_back('{8'h60, 1'b1, 11, 8'h62, 8'h40, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h60, 1'b1, 1, 8'h62, 8'h00, 8'h00, 1'b1, 1'b0, 3'd1});
    tbl.push_back('{8'h60, 1'b1, 11, 8'h60, 8'h00, 8'h02, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h64, 1'b1, 3, 8'h60, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2});
    tbl.push_back('{8'h64, 1'b1, 5, 8'h60, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2});
    tbl.push_back('{8'h60, 1'b1, 2, 8'h60, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2});
    tbl.push_back('{8'h60, 1'b1, 1, 8'h60, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0});
    tbl.push_back('{8'h60, 1'b1, 1, 8'h60, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h64, 1'b1, 3, 8'h60, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2});
    tbl.push_back('{8'h64, 1'b1, 11, 8'h64, 8'h04, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h60, 1'b1, 10, 8'h64, 8'h00, 8'h00, 1'b1, 1'b0, 3'd2});
    tbl.push_back('{8'h64, 1'b1, 3, 8'h64, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0});
    tbl.push_back('{8'h64, 1'b1, 1, 8'h64, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h6C, 1'b1, 5, 8'h64, 8'h00, 8'h00, 1'b1, 1'b0, 3'd3});
    tbl.push_back('{8'h6C, 1'b0, 1, 8'h64, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0});
    tbl.push_back('{8'h6C, 1'b0, 3, 8'h64, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0});
    tbl.push_back('{8'h6C, 1'b1, 1, 8'h64, 8'h00, 8'h00, 1'b1, 1'b0, 3'd3});
    tbl.push_back('{8'h6C, 1'b1, 11, 8'h6C, 8'h08, 8'h00, 1'b0, 1'b0, 3'd0});
    reset = 1'b0;
    q = 8'h00;
    enable = 1'b1;
    adv(2);
    chk_all(-1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    chk("active_ch_reset", -1, 32'(active_ch), 32'd0);
    reset = 1'b1;
    foreach (tbl[i]) begin
      q = tbl[i].q;
      enable = tbl[i].en;
      adv(tbl[i].adv);
      chk_all(i, tbl[i].eq, tbl[i].er, tbl[i].ef, tbl[i].eb, tbl[i].ea, tbl[i].ech);
    end
    q = 8'h08;
    adv(4);
    chk_all(100, 8'h6C, 8'h00, 8'h00, 1'b1, 1'b0, 3'd5);
    #3;
    reset = 1'b0;
    #1;
    chk_all(101, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    chk("active_ch_async", 101, 32'(active_ch), 32'd0);
    adv(1);
    chk_all(102, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    reset = 1'b1;
    adv(1);
    chk_all(103, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    adv(2);
    chk_all(104, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd3);
    adv(10);
    chk_all(105, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd3);
    adv(1);
    chk_all(106, 8'h08, 8'h08, 8'h00, 1'b0, 1'b0, 3'd0);
    adv(1);
    chk_all(107, 8'h08, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
